// File: rtl/pixel_sum_ctrl_if.sv
// Handshake and row-memory bus for pixel_sum_ctrl.
// master: the sum controller; slave: the requester plus image RAM side.
interface pixel_sum_ctrl_if #(
   parameter int IMG_ROWS = 200,
   parameter int IMG_COLS = 300
);
   localparam int AW = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1;

   logic                start;
   logic                busy;
   logic                done;
   logic                mem_en;
   logic [AW-1:0]       mem_addr;
   logic [IMG_COLS-1:0] mem_rdata;
   logic [31:0]         sum;
   logic [31:0]         sum_left;

   modport master (
      input  start, mem_rdata,
      output busy, done, mem_en, mem_addr, sum, sum_left
   );

   modport slave (
      output start, mem_rdata,
      input  busy, done, mem_en, mem_addr, sum, sum_left
   );
endinterface

// File: rtl/pixel_sum_ctrl.sv
// Counts set pixels over a whole bit-per-pixel image read row by row from RAM,
// plus the count within the left region. Optional abort port: PIXEL_SUM_CTRL_ABORT_EN.
module pixel_sum_ctrl #(
   parameter int IMG_ROWS  = 200,
   parameter int IMG_COLS  = 300,
   parameter int LEFT_COLS = 110
) (
   input  logic                clk,
   input  logic                rst,
`ifdef PIXEL_SUM_CTRL_ABORT_EN
   input  logic                abort,
`endif
   pixel_sum_ctrl_if.master    bus
);
   localparam int AW = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] row;
   logic          rvalid;
   logic [31:0]   acc, acc_left;
   logic [31:0]   acc_tot, acc_left_tot;
   logic [31:0]   sum, sum_left;
   logic          abort_i;
   logic          busy, done, mem_en;
   logic [AW-1:0] mem_addr;

`ifdef PIXEL_SUM_CTRL_ABORT_EN
   assign abort_i = abort;
`else
   assign abort_i = 1'b0;
`endif

   function automatic logic [31:0] popcnt(input logic [IMG_COLS-1:0] v,
                                          input int unsigned         n);
      logic [31:0] c;
      c = '0;
      for (int unsigned i = 0; i < IMG_COLS; i++)
         if (i < n) c = c + 32'(v[i]);
      return c;
   endfunction

   // Running totals including the row arriving this cycle, so the DONE load sees the last row.
   always_comb begin
      acc_tot      = acc;
      acc_left_tot = acc_left;
      if (rvalid) begin
         acc_tot      = acc + popcnt(bus.mem_rdata, IMG_COLS);
         acc_left_tot = acc_left + popcnt(bus.mem_rdata, LEFT_COLS);
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      mem_en    = 1'b0;
      mem_addr  = '0;
      case (state)
         IDLE: if (bus.start) state_nxt = RUN;
         RUN: begin
            busy     = 1'b1;
            mem_en   = 1'b1;
            mem_addr = row;
            if (abort_i)                        state_nxt = IDLE;
            else if (row == AW'(IMG_ROWS - 1)) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy      = 1'b1;
            state_nxt = abort_i ? IDLE : DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         row      <= '0;
         rvalid   <= 1'b0;
         acc      <= '0;
         acc_left <= '0;
         sum      <= '0;
         sum_left <= '0;
      end else begin
         state  <= state_nxt;
         rvalid <= mem_en;
         if (state == IDLE && bus.start) begin
            row      <= '0;
            acc      <= '0;
            acc_left <= '0;
         end else begin
            if (state == RUN) row <= row + AW'(1);
            acc      <= acc_tot;
            acc_left <= acc_left_tot;
         end
         if (state == DRAIN && state_nxt == DONE) begin
            sum      <= acc_tot;
            sum_left <= acc_left_tot;
         end
      end
   end

   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.mem_en   = mem_en;
   assign bus.mem_addr = mem_addr;
   assign bus.sum      = sum;
   assign bus.sum_left = sum_left;
endmodule
